// File: rtl/rvfi_pc_chain_monitor_if.sv
// RVFI retirement stream as seen by the PC-chain monitor.
// Valid-only stream: a packet is consumed on every posedge where valid=1; there is no ready/backpressure, and all other fields are don't-care while valid=0.
interface rvfi_pc_chain_monitor_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic [63:0]     order;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic            intr;
    logic            halt;

    modport master (
        output valid,
        output order,
        output pc_rdata,
        output pc_wdata,
        output intr,
        output halt
    );

    modport slave (
        input valid,
        input order,
        input pc_rdata,
        input pc_wdata,
        input intr,
        input halt
    );
endinterface

// File: rtl/rvfi_pc_chain_monitor.sv
// Checks that an RVFI retirement stream is self-consistent (order increments, PC chains),
// plus the reset PC, PC alignment and no retirement after halt. Errors are sticky.
module rvfi_pc_chain_monitor #(
    parameter int              XLEN         = 32,
    parameter int              CNT_W        = 8,
    parameter int              MIN_RETIRE   = 1,
    parameter int              CHK_RESET_PC = 1,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              COMPRESSED   = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   check,
    rvfi_pc_chain_monitor_if.slave rvfi,
    output logic [CNT_W-1:0]       retire_cnt,
    output logic                   err_order,
    output logic                   err_pc,
    output logic                   err_align,
    output logic                   err_halt,
    output logic                   pass,
    output logic [1:0]             state_dbg
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;
    localparam logic [1:0] FAIL   = 2'd3;

    // With compressed instructions only halfword alignment is required.
    localparam logic [XLEN-1:0] ALIGN_MASK = (COMPRESSED != 0) ? XLEN'(1) : XLEN'(3);
    localparam logic [31:0]     MIN_CNT    = 32'(MIN_RETIRE);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [XLEN-1:0] last_pc;
    logic [63:0]     last_order;

    logic det_order;
    logic det_pc;
    logic det_align;
    logic det_halt;
    logic det_any;
    logic any_err;
    logic load_shadow;
    logic cnt_inc;
    logic pass_nxt;

    assign state_dbg = state;
    assign any_err   = err_order | err_pc | err_align | err_halt;

    always_comb begin
        det_order = 1'b0;
        det_pc    = 1'b0;
        det_align = 1'b0;
        det_halt  = 1'b0;
        if (rvfi.valid) begin
            det_align = ((rvfi.pc_rdata & ALIGN_MASK) != '0) ||
                        ((rvfi.pc_wdata & ALIGN_MASK) != '0);
            case (state)
                IDLE: begin
                    det_pc = (CHK_RESET_PC != 0) && (rvfi.pc_rdata != RESET_PC);
                end
                TRACK: begin
                    // Order wraps modulo 2^64, so all-ones followed by zero is legal.
                    det_order = (rvfi.order != (last_order + 64'd1));
                    det_pc    = !rvfi.intr && (rvfi.pc_rdata != last_pc);
                end
                HALTED: begin
                    det_halt = 1'b1;
                end
                default: begin
                end
            endcase
        end
        det_any = det_order | det_pc | det_align | det_halt;
    end

    always_comb begin
        state_nxt = state;
        if (rvfi.valid) begin
            case (state)
                IDLE:    state_nxt = rvfi.halt ? HALTED : TRACK;
                TRACK:   state_nxt = rvfi.halt ? HALTED : TRACK;
                HALTED:  state_nxt = FAIL;
                default: state_nxt = FAIL;
            endcase
        end
        // A detected error overrides every other transition.
        if (det_any) begin
            state_nxt = FAIL;
        end
    end

    assign load_shadow = rvfi.valid && ((state == IDLE) || (state == TRACK));
    assign cnt_inc     = rvfi.valid && (state != FAIL) && (retire_cnt != '1);
    assign pass_nxt    = check && (state != FAIL) && !any_err &&
                         (32'(retire_cnt) >= MIN_CNT) && !det_any;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_pc    <= '0;
            last_order <= '0;
            retire_cnt <= '0;
            err_order  <= 1'b0;
            err_pc     <= 1'b0;
            err_align  <= 1'b0;
            err_halt   <= 1'b0;
            pass       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_shadow) begin
                last_pc    <= rvfi.pc_wdata;
                last_order <= rvfi.order;
            end
            if (cnt_inc) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
            err_order <= err_order | det_order;
            err_pc    <= err_pc    | det_pc;
            err_align <= err_align | det_align;
            err_halt  <= err_halt  | det_halt;
            pass      <= pass_nxt;
        end
    end
endmodule

// File: tb/tb_rvfi_pc_chain_monitor.sv
// Bench for rvfi_pc_chain_monitor: two instances (default, and CNT_W=2/COMPRESSED=1) share one
// stimulus stream; a behavioural model queues expected outputs that a monitor pops every cycle.
module tb_rvfi_pc_chain_monitor;
  localparam int W = 26;

  logic clock;
  logic reset;
  logic check;

  logic [7:0] retire_cnt_a;
  logic [1:0] retire_cnt_b;
  logic err_order_a, err_pc_a, err_align_a, err_halt_a, pass_a;
  logic err_order_b, err_pc_b, err_align_b, err_halt_b, pass_b;
  logic [1:0] state_a, state_b;

  rvfi_pc_chain_monitor_if #(.XLEN(32)) rvfi_a ();
  rvfi_pc_chain_monitor_if #(.XLEN(32)) rvfi_b ();

  rvfi_pc_chain_monitor dut_a (
    .clock(clock), .reset(reset), .check(check), .rvfi(rvfi_a),
    .retire_cnt(retire_cnt_a), .err_order(err_order_a), .err_pc(err_pc_a),
    .err_align(err_align_a), .err_halt(err_halt_a), .pass(pass_a), .state_dbg(state_a)
  );

  rvfi_pc_chain_monitor #(.CNT_W(2), .COMPRESSED(1)) dut_b (
    .clock(clock), .reset(reset), .check(check), .rvfi(rvfi_b),
    .retire_cnt(retire_cnt_b), .err_order(err_order_b), .err_pc(err_pc_b),
    .err_align(err_align_b), .err_halt(err_halt_b), .pass(pass_b), .state_dbg(state_b)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Per instance: index 0 = default config, index 1 = CNT_W=2, COMPRESSED=1.
  bit          m_started[2];
  bit          m_halted[2];
  logic [31:0] m_last_pc[2];
  logic [63:0] m_last_ord[2];
  int          m_cnt[2];
  bit          m_eo[2], m_ep[2], m_ea[2], m_eh[2], m_pass[2];

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic model_step(input int d, input bit rst, input bit chk, input bit vld,
                            input logic [63:0] ord, input logic [31:0] rd, input logic [31:0] wd,
                            input bit intr, input bit halt);
    bit failed;
    bit n_eo, n_ep, n_ea, n_eh;
    int cmax;
    logic [31:0] mask;
    cmax = (d == 0) ? 255 : 3;
    mask = (d == 0) ? 32'h3 : 32'h1;
    if (rst) begin
      m_started[d] = 0; m_halted[d] = 0; m_last_pc[d] = '0; m_last_ord[d] = '0; m_cnt[d] = 0;
      m_eo[d] = 0; m_ep[d] = 0; m_ea[d] = 0; m_eh[d] = 0; m_pass[d] = 0;
      return;
    end
    failed = m_eo[d] | m_ep[d] | m_ea[d] | m_eh[d];
    n_eo = 0; n_ep = 0; n_eh = 0;
    n_ea = vld && (((rd & mask) != 0) || ((wd & mask) != 0));
    if (vld && !failed) begin
      if (!m_started[d]) n_ep = (rd != 32'h0);
      else if (m_halted[d]) n_eh = 1;
      else begin
        n_eo = (ord != m_last_ord[d] + 64'd1);
        n_ep = !intr && (rd != m_last_pc[d]);
      end
    end
    m_pass[d] = chk && !failed && (m_cnt[d] >= 1) && !(n_eo | n_ep | n_ea | n_eh);
    if (vld && !failed) begin
      if (m_cnt[d] < cmax) m_cnt[d]++;
      if (!m_halted[d]) begin
        m_last_pc[d] = wd; m_last_ord[d] = ord; m_started[d] = 1;
        if (halt) m_halted[d] = 1;
      end
    end
    m_eo[d] |= n_eo; m_ep[d] |= n_ep; m_ea[d] |= n_ea; m_eh[d] |= n_eh;
  endtask

  function automatic logic [12:0] model_pack(input int d);
    return {8'(m_cnt[d]), m_eo[d], m_ep[d], m_ea[d], m_eh[d], m_pass[d]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit rst, input bit chk, input bit vld, input logic [63:0] ord,
                       input logic [31:0] rd, input logic [31:0] wd, input bit intr, input bit halt);
    @(negedge clock);
    reset = rst; check = chk;
    rvfi_a.valid = vld; rvfi_a.order = ord; rvfi_a.pc_rdata = rd; rvfi_a.pc_wdata = wd;
    rvfi_a.intr = intr; rvfi_a.halt = halt;
    rvfi_b.valid = vld; rvfi_b.order = ord; rvfi_b.pc_rdata = rd; rvfi_b.pc_wdata = wd;
    rvfi_b.intr = intr; rvfi_b.halt = halt;
    for (int d = 0; d < 2; d++) model_step(d, rst, chk, vld, ord, rd, wd, intr, halt);
    exp_q.push_back({model_pack(0), model_pack(1)});
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, '0, '0, '0, 0, 0);
  endtask

  task automatic retire(input logic [63:0] ord, input logic [31:0] rd, input logic [31:0] wd,
                        input bit intr = 0, input bit halt = 0, input bit chk = 0);
    drive(0, chk, 1, ord, rd, wd, intr, halt);
  endtask

  task automatic idle(input bit chk);
    drive(0, chk, 0, 64'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] exp;
    logic [12:0] got_a, got_b;
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got_a = {retire_cnt_a, err_order_a, err_pc_a, err_align_a, err_halt_a, pass_a};
        got_b = {6'b0, retire_cnt_b, err_order_b, err_pc_b, err_align_b, err_halt_b, pass_b};
        checks++;
        if (got_a !== exp[25:13]) begin
          errors++;
          $display("FAIL dut_a cycle %0d: got cnt=%0d eo/ep/ea/eh/pass=%b, expected cnt=%0d eo/ep/ea/eh/pass=%b",
                   cyc, got_a[12:5], got_a[4:0], exp[25:18], exp[17:13]);
        end
        checks++;
        if (got_b !== exp[12:0]) begin
          errors++;
          $display("FAIL dut_b cycle %0d: got cnt=%0d eo/ep/ea/eh/pass=%b, expected cnt=%0d eo/ep/ea/eh/pass=%b",
                   cyc, got_b[12:5], got_b[4:0], exp[12:5], exp[4:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] g_pc;
  logic [63:0] g_ord;

  task automatic random_episode();
    int n;
    int r;
    bit first;
    logic [31:0] rd, wd;
    logic [63:0] ord;
    bit intr, halt, vld, chk;
    do_reset($urandom_range(1, 2));
    g_pc  = 32'h0;
    g_ord = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFD : {32'h0, $urandom};
    first = 1;
    n = $urandom_range(20, 60);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      vld = (r >= 15);
      rd = g_pc; wd = g_pc + 32'd4; ord = g_ord + 64'd1; intr = 0; halt = 0;
      r = $urandom_range(0, 99);
      if (r < 4) ord = g_ord + 64'd2;
      else if (r < 7) ord = g_ord;
      else if (r < 11) rd = g_pc + 32'd16;
      else if (r < 17) begin rd = g_pc + 32'd32; intr = 1; end
      else if (r < 20) wd = g_pc + 32'd6;
      else if (r < 22) wd = g_pc + 32'd5;
      else if (r < 25) halt = 1;
      else if (r < 35) wd = {$urandom_range(0, 1023), 2'b00};
      if (first && $urandom_range(0, 19) == 0) rd = 32'h100;
      chk = ($urandom_range(0, 4) == 0) && (!vld || (m_cnt[0] >= 1 && m_cnt[1] >= 1));
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
        g_pc = 32'h0; first = 1;
      end else if (vld) begin
        retire(ord, rd, wd, intr, halt, chk);
        g_pc = wd; g_ord = ord; first = 0;
      end else begin
        idle(chk);
      end
    end
  endtask

  initial begin
    reset = 1'b1; check = 1'b0;
    rvfi_a.valid = 0; rvfi_a.order = '0; rvfi_a.pc_rdata = '0; rvfi_a.pc_wdata = '0;
    rvfi_a.intr = 0; rvfi_a.halt = 0;
    rvfi_b.valid = 0; rvfi_b.order = '0; rvfi_b.pc_rdata = '0; rvfi_b.pc_wdata = '0;
    rvfi_b.intr = 0; rvfi_b.halt = 0;

    // basic chain, then pass
    do_reset(2);
    retire(0, 32'h0, 32'h4);
    retire(1, 32'h4, 32'h8);
    idle(1); idle(0);

    // PC chain break without and with intr
    do_reset(2);
    retire(0, 32'h0, 32'h4);
    retire(1, 32'h8, 32'hC);
    idle(0); idle(1);
    do_reset(1);
    retire(0, 32'h0, 32'h4);
    retire(1, 32'h8, 32'hC, 1);
    idle(1);

    // order gap; order wrap across all-ones
    do_reset(1);
    retire(5, 32'h0, 32'h4);
    retire(7, 32'h4, 32'h8);
    idle(1);
    do_reset(1);
    retire(64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 32'h4);
    retire(0, 32'h4, 32'h8);
    idle(1);

    // retirement after halt; count frozen in FAIL
    do_reset(1);
    retire(0, 32'h0, 32'h4, 0, 1);
    retire(1, 32'h4, 32'h8);
    idle(1);
    retire(2, 32'h8, 32'hC);
    idle(0);

    // alignment: halfword PCs legal only for the compressed instance
    do_reset(1);
    retire(0, 32'h0, 32'h2);
    retire(1, 32'h2, 32'h4);
    idle(1);
    retire(2, 32'h4, 32'h5);
    idle(0);

    // simultaneous check and failing valid
    do_reset(1);
    retire(0, 32'h0, 32'h4);
    retire(3, 32'h4, 32'h8, 0, 0, 1);
    idle(1);

    // counter saturation, then reset mid-track and wrong reset PC
    do_reset(1);
    for (int i = 0; i < 5; i++) retire(64'(i), 32'(4 * i), 32'(4 * i + 4));
    idle(1);
    do_reset(1);
    retire(0, 32'h10, 32'h14);
    idle(1);

    for (int e = 0; e < 40; e++) random_episode();
    idle(0); idle(0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
